// File: rtl/signal_condition_ip_if.sv
// ---------------------------------------------------------------------------
// signal_condition_ip_if
// Avalon-MM slave bus bundle for signal_condition_ip.
//   avs_chipselect  : slave select
//   avs_address[1:0]: register word address
//   avs_read        : read strobe
//   avs_write       : write strobe
//   avs_writedata   : 32-bit write data
//   avs_readdata    : 32-bit read data (combinational from the slave)
// Modports: master (drives the bus), slave (the register block).
// ---------------------------------------------------------------------------
interface signal_condition_ip_if;
    logic        avs_chipselect;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_chipselect,
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_chipselect,
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/signal_condition_ip.sv
// ---------------------------------------------------------------------------
// signal_condition_ip
// Conditions a raw asynchronous signal: synchronizer, glitch filter, rising
// edge detect, edge counter and a divide-by-DIV toggling prescaler output.
// Ports:
//   csi_clk    : system clock, all logic on rising edge
//   csi_reset  : synchronous active-high reset
//   avs        : Avalon-MM slave bundle (signal_condition_ip_if.slave)
//   coe_S_in   : raw asynchronous measured signal
//   coe_S_out  : conditioned, prescaled square wave
// Registers: 0 CTRL {FILT_LEN[15:8], EN[0]}, 1 DIV[15:0], 2 EDGE_CNT (ro,
// write clears), 3 STATUS {OVF[2], coe_S_out[1], filt[0]} (write 1 to bit 2
// clears OVF).
// ---------------------------------------------------------------------------
module signal_condition_ip #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 csi_clk,
    input  logic                 csi_reset,
    signal_condition_ip_if.slave avs,
    input  logic                 coe_S_in,
    output logic                 coe_S_out
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filt;
    logic                   r_filt_d;
    logic [7:0]             r_st;
    logic [15:0]            r_pc;
    logic                   r_out;
    logic [31:0]            r_edge_cnt;
    logic                   r_ovf;
    logic                   r_en;
    logic [7:0]             r_filt_len;
    logic [15:0]            r_div;

    logic        w_s;
    logic        w_rise;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_div;
    logic        w_wr_edge;
    logic        w_wr_stat;
    logic        w_flen_chg;
    logic        w_cnt_inc;
    logic        w_wrap;
    logic [15:0] w_div_eff;
    logic        w_unused;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_rise     = r_filt & ~r_filt_d;
    assign w_wr       = avs.avs_chipselect & avs.avs_write;
    assign w_wr_ctrl  = w_wr & (avs.avs_address == 2'd0);
    assign w_wr_div   = w_wr & (avs.avs_address == 2'd1);
    assign w_wr_edge  = w_wr & (avs.avs_address == 2'd2);
    assign w_wr_stat  = w_wr & (avs.avs_address == 2'd3);
    assign w_flen_chg = w_wr_ctrl & (avs.avs_writedata[15:8] != r_filt_len);
    assign w_div_eff  = (r_div == 16'd0) ? 16'd1 : r_div;
    // A counter clear beats a same-cycle increment, so no wrap is seen then.
    assign w_cnt_inc  = r_en & w_rise & ~w_wr_edge;
    assign w_wrap     = w_cnt_inc & (r_edge_cnt == 32'hFFFF_FFFF);
    assign w_unused   = ^avs.avs_writedata[31:16];

    assign coe_S_out  = r_out;

    // Input synchronizer; index 0 samples the pin.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], coe_S_in};
        end
    end

    // Glitch filter: filt follows s only after FILT_LEN+1 consecutive
    // mismatching cycles.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            r_filt   <= 1'b0;
            r_filt_d <= 1'b0;
            r_st     <= 8'd0;
        end else begin
            r_filt_d <= r_filt;
            if (w_s == r_filt) begin
                r_st <= 8'd0;
            end else if (r_st == r_filt_len) begin
                r_filt <= w_s;
                r_st   <= 8'd0;
            end else begin
                r_st <= r_st + 8'd1;
            end
            // A new filter length restarts the stability count.
            if (w_flen_chg) begin
                r_st <= 8'd0;
            end
        end
    end

    // Prescaler: toggle the output every DIV_EFF filtered rises.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            r_pc  <= 16'd0;
            r_out <= 1'b0;
        end else if (!r_en) begin
            r_pc  <= 16'd0;
            r_out <= 1'b0;
        end else if (w_wr_div) begin
            r_pc <= 16'd0;
        end else if (w_rise) begin
            if (r_pc == w_div_eff - 16'd1) begin
                r_pc  <= 16'd0;
                r_out <= ~r_out;
            end else begin
                r_pc <= r_pc + 16'd1;
            end
        end
    end

    // Edge counter with sticky overflow; set beats clear.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            r_edge_cnt <= 32'd0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_wr_edge) begin
                r_edge_cnt <= 32'd0;
            end else if (w_cnt_inc) begin
                r_edge_cnt <= r_edge_cnt + 32'd1;
            end
            if (w_wrap) begin
                r_ovf <= 1'b1;
            end else if (w_wr_stat && avs.avs_writedata[2]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Control registers.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            r_en       <= 1'b0;
            r_filt_len <= 8'd0;
            r_div      <= 16'd1;
        end else begin
            if (w_wr_ctrl) begin
                r_en       <= avs.avs_writedata[0];
                r_filt_len <= avs.avs_writedata[15:8];
            end
            if (w_wr_div) begin
                r_div <= avs.avs_writedata[15:0];
            end
        end
    end

    // Combinational read mux.
    always_comb begin
        avs.avs_readdata = 32'h0;
        if (avs.avs_chipselect && avs.avs_read) begin
            unique case (avs.avs_address)
                2'd0: avs.avs_readdata = {16'h0, r_filt_len, 7'h0, r_en};
                2'd1: avs.avs_readdata = {16'h0, r_div};
                2'd2: avs.avs_readdata = r_edge_cnt;
                2'd3: avs.avs_readdata = {29'h0, r_ovf, r_out, r_filt};
                default: avs.avs_readdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_signal_condition_ip.sv
// Bench for signal_condition_ip: directed scenarios plus a randomized phase,
// all checked against a behavioural model of the conditioning chain.
module tb_signal_condition_ip;

    localparam int unsigned SYNC = 2;

    logic csi_clk;
    logic csi_reset;
    logic coe_S_in;
    logic coe_S_out;

    signal_condition_ip_if bus ();

    signal_condition_ip #(
        .SYNC_STAGES(SYNC)
    ) dut (
        .csi_clk  (csi_clk),
        .csi_reset(csi_reset),
        .avs      (bus),
        .coe_S_in (coe_S_in),
        .coe_S_out(coe_S_out)
    );

    initial csi_clk = 1'b0;
    always #5 csi_clk = ~csi_clk;

    int n_cmp;
    int n_bad;
    int cyc;
    int tog;
    int tog_q[$];
    logic prev_out;

    // Behavioural model state.
    bit          m_pipe[$];   // index 0 = newest raw sample
    bit          m_hist[$];   // synchronized samples since filt/flen last changed
    bit          m_filt;
    bit          m_filt_d;
    bit          m_en;
    logic [7:0]  m_flen;
    logic [15:0] m_div;
    logic [31:0] m_cnt;
    bit          m_ovf;
    bit          m_out;
    bit          m_base;      // output level when the rise count last restarted
    int unsigned m_nrise;     // rises since the count last restarted

    function automatic int unsigned div_eff(input logic [15:0] d);
        return (d == 16'd0) ? 1 : int'(d);
    endfunction

    function automatic logic [31:0] reg_val(input logic [1:0] a);
        case (a)
            2'd0:    return {16'h0, m_flen, 7'h0, m_en};
            2'd1:    return {16'h0, m_div};
            2'd2:    return m_cnt;
            default: return {29'h0, m_ovf, m_out, m_filt};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit s;
        bit rise;
        bit wr;
        bit wrap;
        bit all_diff;
        bit old_filt;
        int n;
        logic [1:0] a;
        logic [31:0] d;
        if (csi_reset) begin
            m_pipe.delete();
            for (int i = 0; i < int'(SYNC); i++) m_pipe.push_back(1'b0);
            m_hist.delete();
            m_filt = 0; m_filt_d = 0; m_en = 0; m_flen = 8'd0; m_div = 16'd1;
            m_cnt = 32'd0; m_ovf = 0; m_out = 0; m_base = 0; m_nrise = 0;
            return;
        end
        s        = m_pipe[SYNC-1];
        rise     = m_filt & ~m_filt_d;
        old_filt = m_filt;
        wr       = bus.avs_chipselect & bus.avs_write;
        a        = bus.avs_address;
        d        = bus.avs_writedata;
        wrap     = 0;
        m_pipe.push_front(coe_S_in);
        void'(m_pipe.pop_back());
        // filt flips once the last FILT_LEN+1 samples all disagree with it
        m_hist.push_back(s);
        if (m_hist.size() > 300) void'(m_hist.pop_front());
        n = m_hist.size();
        all_diff = (n >= int'(m_flen) + 1);
        if (all_diff) begin
            for (int i = 0; i <= int'(m_flen); i++) begin
                if (m_hist[n-1-i] == m_filt) all_diff = 0;
            end
        end
        if (all_diff) begin
            m_filt = s;
            m_hist.delete();
        end
        m_filt_d = old_filt;
        // output level = base flipped once per completed group of DIV_EFF rises
        if (!m_en) begin
            m_nrise = 0; m_base = 0; m_out = 0;
        end else if (wr && a == 2'd1) begin
            m_nrise = 0; m_base = m_out;
        end else if (rise) begin
            m_nrise++;
            m_out = m_base ^ 1'((m_nrise / div_eff(m_div)) % 2);
        end
        if (wr && a == 2'd2) begin
            m_cnt = 32'd0;
        end else if (m_en && rise) begin
            if (m_cnt == 32'hFFFF_FFFF) wrap = 1;
            m_cnt = m_cnt + 32'd1;
        end
        if (wrap) m_ovf = 1;
        else if (wr && a == 2'd3 && d[2]) m_ovf = 0;
        if (wr && a == 2'd0) begin
            if (d[15:8] != m_flen) m_hist.delete();
            m_en   = d[0];
            m_flen = d[15:8];
        end
        if (wr && a == 2'd1) m_div = d[15:0];
    endtask

    task automatic tick();
        @(posedge csi_clk);
        model_edge();
        @(negedge csi_clk);
        cyc++;
        chk("coe_S_out", 32'(coe_S_out), 32'(m_out));
        if (coe_S_out !== prev_out) begin
            tog++;
            tog_q.push_back(cyc);
        end
        prev_out = coe_S_out;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        bus.avs_chipselect = 1'b1;
        bus.avs_write      = 1'b1;
        bus.avs_address    = a;
        bus.avs_writedata  = d;
        tick();
        bus.avs_chipselect = 1'b0;
        bus.avs_write      = 1'b0;
        bus.avs_writedata  = 32'h0;
    endtask

    // Reads are combinational: present, settle, compare, withdraw.
    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus.avs_chipselect = 1'b1;
        bus.avs_read       = 1'b1;
        bus.avs_address    = a;
        #1;
        v = bus.avs_readdata;
        bus.avs_chipselect = 1'b0;
        bus.avs_read       = 1'b0;
    endtask

    task automatic rd_model(input string tag, input logic [1:0] a);
        logic [31:0] v;
        rd(a, v);
        chk(tag, v, reg_val(a));
    endtask

    task automatic rd_const(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        chk(tag, v, exp);
    endtask

    task automatic periods(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            coe_S_in = 1'b1;
            ticks(hi);
            coe_S_in = 1'b0;
            ticks(lo);
        end
    endtask

    initial begin
        logic [31:0] v;
        logic        out_before;
        int          r;
        n_cmp = 0; n_bad = 0; cyc = 0; tog = 0; prev_out = 1'b0;
        coe_S_in = 1'b0;
        bus.avs_chipselect = 1'b0;
        bus.avs_read       = 1'b0;
        bus.avs_write      = 1'b0;
        bus.avs_address    = 2'd0;
        bus.avs_writedata  = 32'h0;
        csi_reset = 1'b1;
        @(negedge csi_clk);
        ticks(3);

        // Reset values, with and without a read presented.
        chk("rd_idle_in_reset", bus.avs_readdata, 32'h0);
        rd_const("div_in_reset", 2'd1, 32'h1);
        csi_reset = 1'b0;
        tick();
        rd_const("ctrl_reset", 2'd0, 32'h0);
        rd_const("div_reset", 2'd1, 32'h1);
        rd_const("edge_reset", 2'd2, 32'h0);
        rd_const("status_reset", 2'd3, 32'h0);

        // Clean 20-clk input periods, DIV=1: one toggle per rise.
        wr_reg(2'd0, 32'h1);
        tog = 0;
        tog_q.delete();
        periods(10, 10, 10);
        ticks(6);
        rd_const("edge_10_periods", 2'd2, 32'd10);
        chk("toggles_div1", 32'(tog), 32'd10);
        if (tog_q.size() >= 10) begin
            chk("out_half_period_a", 32'(tog_q[1] - tog_q[0]), 32'd20);
            chk("out_half_period_b", 32'(tog_q[9] - tog_q[8]), 32'd20);
        end else begin
            chk("out_toggle_count", 32'(tog_q.size()), 32'd10);
        end

        // FILT_LEN=3: 3-cycle glitch rejected, 4-cycle pulse accepted.
        wr_reg(2'd0, 32'h0301);
        ticks(10);
        coe_S_in = 1'b1;
        ticks(3);
        coe_S_in = 1'b0;
        ticks(12);
        rd(2'd3, v);
        chk("glitch_filt_low", 32'(v[0]), 32'd0);
        rd_const("glitch_edge_same", 2'd2, 32'd10);
        coe_S_in = 1'b1;
        ticks(4);
        coe_S_in = 1'b0;
        ticks(SYNC - 1);
        rd(2'd3, v);
        chk("pulse_filt_early", 32'(v[0]), 32'd0);
        tick();
        rd(2'd3, v);
        chk("pulse_filt_at_sync_plus_4", 32'(v[0]), 32'd1);
        ticks(12);
        rd_const("pulse_edge", 2'd2, 32'd11);

        // DIV=5: 20 rises give 4 toggles; DIV=0 acts as DIV=1.
        wr_reg(2'd0, 32'h1);
        wr_reg(2'd1, 32'd5);
        tog = 0;
        periods(20, 4, 4);
        ticks(6);
        chk("toggles_div5", 32'(tog), 32'd4);
        wr_reg(2'd1, 32'd0);
        tog = 0;
        periods(4, 4, 4);
        ticks(6);
        chk("toggles_div0", 32'(tog), 32'd4);
        rd_model("div_readback", 2'd1);

        // Counter wrap sets sticky OVF; write 1 to STATUS bit 2 clears it.
        ticks(4);
        force dut.r_edge_cnt = 32'hFFFF_FFFE;
        tick();
        release dut.r_edge_cnt;
        m_cnt = 32'hFFFF_FFFE;
        rd_const("edge_preset", 2'd2, 32'hFFFF_FFFE);
        periods(2, 4, 4);
        ticks(6);
        rd_const("edge_wrapped", 2'd2, 32'h0);
        rd(2'd3, v);
        chk("ovf_set", 32'(v[2]), 32'd1);
        wr_reg(2'd3, 32'h4);
        rd(2'd3, v);
        chk("ovf_cleared", 32'(v[2]), 32'd0);

        // EDGE_CNT write in the same cycle as a counted rise reads back 0.
        coe_S_in = 1'b1;
        ticks(SYNC + 1);
        wr_reg(2'd2, 32'h123);
        rd_const("edge_clear_wins", 2'd2, 32'h0);
        coe_S_in = 1'b0;
        ticks(6);
        rd_const("edge_after_clear", 2'd2, 32'h0);

        // DIV rewrite mid-count restarts the prescaler, output held.
        wr_reg(2'd1, 32'd4);
        periods(2, 4, 4);
        out_before = coe_S_out;
        wr_reg(2'd1, 32'd4);
        chk("out_held_on_div_write", 32'(coe_S_out), 32'(out_before));
        tog = 0;
        periods(3, 4, 4);
        ticks(4);
        chk("no_toggle_3_rises", 32'(tog), 32'd0);
        periods(1, 4, 4);
        ticks(4);
        chk("toggle_4th_rise", 32'(tog), 32'd1);

        // Reset mid-operation.
        wr_reg(2'd1, 32'd1);
        periods(1, 4, 4);
        ticks(4);
        coe_S_in = 1'b1;
        ticks(2);
        csi_reset = 1'b1;
        tick();
        csi_reset = 1'b0;
        rd_const("ctrl_after_reset", 2'd0, 32'h0);
        rd_const("div_after_reset", 2'd1, 32'h1);
        rd_const("edge_after_reset", 2'd2, 32'h0);
        chk("out_after_reset", 32'(coe_S_out), 32'd0);
        coe_S_in = 1'b0;
        ticks(6);

        // Randomized traffic against the model.
        wr_reg(2'd0, 32'h1);
        for (int it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                case ($urandom_range(0, 3))
                    0: wr_reg(2'd0, {16'h0, 8'($urandom_range(0, 4)), 7'h0,
                                     1'($urandom_range(0, 3) != 0)});
                    1: wr_reg(2'd1, 32'($urandom_range(0, 6)));
                    2: wr_reg(2'd2, $urandom);
                    default: wr_reg(2'd3, $urandom);
                endcase
            end else if (r < 10) begin
                csi_reset = 1'b1;
                tick();
                csi_reset = 1'b0;
            end else if (r < 25) begin
                rd_model("rand_read", 2'($urandom_range(0, 3)));
            end else begin
                coe_S_in = ~coe_S_in;
                ticks(int'($urandom_range(1, 10)));
            end
        end
        ticks(10);
        for (int a = 0; a < 4; a++) rd_model("final_read", 2'(a));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
